// File: rtl/sync_pkg.sv
// Shared definitions for the sync frame arbiter: framer defaults, FSM encoding
// and the fill-block source id.
package sync_pkg;

    localparam logic [7:0]  SYNC_MARKER     = 8'h47;
    localparam int unsigned DEF_PAYLOAD_LEN = 255;
    localparam logic [7:0]  PADDING_BYTE    = 8'h00;
    localparam logic [7:0]  DEF_FILL_BYTE   = 8'h55;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StFill = 2'd2
    } state_e;

    // All-ones id of width id_w, used to tag fill blocks on tuser.
    function automatic logic [7:0] fill_id(input int unsigned id_w);
        fill_id = 8'((1 << id_w) - 1);
    endfunction

endpackage

// File: rtl/sync_rr_arb.sv
// Round-robin request picker: first requester at or after rr_ptr_i, wrapping.
// Purely combinational; the caller registers the result.
module sync_rr_arb #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_SRC-1:0] gnt_oh_o,
    output logic [PTR_W-1:0]   gnt_id_o,
    output logic               gnt_vld_o
);

    // Scan sources starting at the pointer; the first hit wins.
    always_comb begin
        logic        found;
        int unsigned idx;
        found     = 1'b0;
        idx       = 0;
        gnt_oh_o  = '0;
        gnt_id_o  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr_i) + k) % NUM_SRC;
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_id_o      = PTR_W'(idx);
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/sync_frame_arbiter.sv
// Schedules NUM_SRC byte streams onto the framer input, one full payload block
// per grant, round-robin. Optional idle fill blocks are enabled by defining
// FILL_BLOCK_EN.
module sync_frame_arbiter
    import sync_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned PAYLOAD_LEN  = DEF_PAYLOAD_LEN,
    parameter logic [7:0]  FILL_BYTE    = DEF_FILL_BYTE,
    parameter int unsigned IDLE_TIMEOUT = 1024,
    localparam int unsigned ID_W = ($clog2(NUM_SRC + 1) > 1) ? $clog2(NUM_SRC + 1) : 1
) (
    input  logic                 core_clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC*8-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]   s_axis_tvalid,
    output logic [NUM_SRC-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic [ID_W-1:0]      m_axis_tuser,
    input  logic                 m_axis_tready,
    output logic                 grant_busy,
    output logic [15:0]          block_cnt
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [PTR_W-1:0] LastSrc = PTR_W'(NUM_SRC - 1);

`ifdef FILL_BLOCK_EN
    localparam int unsigned IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IW-1:0]  IdleLast  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [7:0]     FillIdAll = fill_id(ID_W);
    localparam logic [ID_W-1:0] FillId   = FillIdAll[ID_W-1:0];
    logic [IW-1:0] idle_cnt_q;
`endif

    state_e             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   gnt_id_q;
    logic [NUM_SRC-1:0] gnt_oh_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [15:0]        block_cnt_q;
    logic               busy_q;

    logic [NUM_SRC-1:0] arb_oh;
    logic [PTR_W-1:0]   arb_id;
    logic               arb_vld;
    logic               hs;
    logic               last_beat;

    sync_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i     (s_axis_tvalid),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_id_o  (arb_id),
        .gnt_vld_o (arb_vld)
    );

    assign hs         = m_axis_tvalid & m_axis_tready;
    assign last_beat  = (byte_cnt_q == LastCnt);
    assign grant_busy = busy_q;
    assign block_cnt  = block_cnt_q;

    // Arbitration FSM with byte, block and idle counters.
    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            gnt_oh_q    <= '0;
            byte_cnt_q  <= '0;
            block_cnt_q <= '0;
            busy_q      <= 1'b0;
`ifdef FILL_BLOCK_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (arb_vld) begin
                        gnt_id_q <= arb_id;
                        gnt_oh_q <= arb_oh;
                        state_q  <= StXfer;
                        busy_q   <= 1'b1;
`ifdef FILL_BLOCK_EN
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IdleLast) begin
                        state_q    <= StFill;
                        busy_q     <= 1'b1;
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
`endif
                    end
                end
                StXfer, StFill: begin
                    if (hs) begin
                        if (last_beat) begin
                            byte_cnt_q  <= '0;
                            block_cnt_q <= block_cnt_q + 16'd1;
                            state_q     <= StIdle;
                            busy_q      <= 1'b0;
                            // Fill blocks leave the round-robin position untouched.
                            if (state_q == StXfer) begin
                                rr_ptr_q <= (gnt_id_q == LastSrc) ? '0 : gnt_id_q + 1'b1;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Zero-latency pass-through of the granted source, or the fill pattern.
    always_comb begin
        m_axis_tdata  = FILL_BYTE;
        m_axis_tvalid = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        m_axis_tlast  = (state_q != StIdle) && last_beat;
        case (state_q)
            StXfer: begin
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    if (gnt_id_q == PTR_W'(i)) begin
                        m_axis_tdata  = s_axis_tdata[8*i +: 8];
                        m_axis_tvalid = s_axis_tvalid[i];
                    end
                end
                m_axis_tuser  = ID_W'(gnt_id_q);
                s_axis_tready = gnt_oh_q & {NUM_SRC{m_axis_tready}};
            end
`ifdef FILL_BLOCK_EN
            StFill: begin
                m_axis_tvalid = 1'b1;
                m_axis_tuser  = FillId;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sync_frame_arbiter.sv
// Scoreboard bench for sync_frame_arbiter: expected beats are queued as blocks
// are requested and popped by a monitor on every output handshake.
module tb_sync_frame_arbiter;

    localparam int PAYLOAD = 255;

    logic        core_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_axis_tdata;
    logic [1:0]  s_axis_tvalid = '0;
    logic [1:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic        grant_busy;
    logic [15:0] block_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [1:0] u;
    } beat_t;

    beat_t      exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         beat_cnt = 0;
    int         last_gap = -1;
    int         last_cyc = 0;
    bit         after_last = 0;
    bit         mon_en = 0;
    logic [7:0] src_byte[2];
    logic [7:0] exp_next[2];
    int         src_hs[2];

    always #5 core_clk = ~core_clk;

    sync_frame_arbiter #(
        .NUM_SRC      (2),
        .PAYLOAD_LEN  (PAYLOAD),
        .FILL_BYTE    (8'h55),
        .IDLE_TIMEOUT (16)
    ) dut (
        .core_clk      (core_clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .grant_busy    (grant_busy),
        .block_cnt     (block_cnt)
    );

    // Monitor: pop one expected beat per handshake, and watch ready exclusivity.
    always @(negedge core_clk) begin
        beat_t e;
        beat_t got;
        cyc++;
        if (mon_en && rst_n) begin
            n_checks++;
            if ($countones(s_axis_tready) > 1) begin
                n_fail++;
                $display("FAIL ready_onehot s_axis_tready=%b, required at most one bit", s_axis_tready);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat got data=%02h last=%b user=%0d, required no beat",
                             got.d, got.l, got.u);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL beat_%0d got data=%02h last=%b user=%0d, required data=%02h last=%b user=%0d",
                                 beat_cnt, got.d, got.l, got.u, e.d, e.l, e.u);
                    end
                end
                beat_cnt++;
                if (after_last) begin
                    last_gap   = cyc - last_cyc - 1;
                    after_last = 0;
                end
                if (m_axis_tlast) begin
                    after_last = 1;
                    last_cyc   = cyc;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    task automatic push_src_block(input int s);
        beat_t b;
        for (int k = 0; k < PAYLOAD; k++) begin
            b.d = exp_next[s];
            b.l = (k == PAYLOAD - 1);
            b.u = 2'(s);
            exp_q.push_back(b);
            exp_next[s]++;
        end
    endtask

    task automatic push_fill_block();
        beat_t b;
        for (int k = 0; k < PAYLOAD; k++) begin
            b.d = 8'h55;
            b.l = (k == PAYLOAD - 1);
            b.u = 2'b11;
            exp_q.push_back(b);
        end
    endtask

    // One clock; sources advance on the handshakes taken at this edge.
    task automatic tick();
        logic [1:0] hs;
        #1;
        hs = s_axis_tvalid & s_axis_tready;
        @(posedge core_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                src_byte[i]++;
                src_hs[i]++;
            end
        end
        s_axis_tdata = {src_byte[1], src_byte[0]};
    endtask

    task automatic run_blocks(input int budget, output bit done);
        done = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (exp_q.size() == 0) begin
                s_axis_tvalid = '0;
                done = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        exp_q.delete();
        src_byte[0] = 8'h00; src_byte[1] = 8'h80;
        exp_next[0] = 8'h00; exp_next[1] = 8'h80;
        src_hs[0] = 0; src_hs[1] = 0;
        s_axis_tdata = {src_byte[1], src_byte[0]};
        after_last = 0;
        last_gap = -1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_axis_tvalid = 2'b11;
        m_axis_tready = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tvalid got %b, required 0", m_axis_tvalid);
        end
        n_checks++;
        if (s_axis_tready !== 2'b00) begin
            n_fail++; $display("FAIL reset_tready got %b, required 00", s_axis_tready);
        end
        n_checks++;
        if (m_axis_tlast !== 1'b0) begin
            n_fail++; $display("FAIL reset_tlast got %b, required 0", m_axis_tlast);
        end
        n_checks++;
        if (grant_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b, required 0", grant_busy);
        end
        n_checks++;
        if (block_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_block_cnt got %0d, required 0", block_cnt);
        end
        // Release with both requesting and the framer stalled: src0 wins after one cycle.
        m_axis_tready = 1'b0;
        rst_n = 1'b1;
        mon_en = 1;
        tick();
        #1;
        n_checks++;
        if ({grant_busy, m_axis_tvalid, m_axis_tuser} !== {1'b1, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL first_grant got busy=%b tvalid=%b tuser=%0d, required busy=1 tvalid=1 tuser=0",
                     grant_busy, m_axis_tvalid, m_axis_tuser);
        end
    endtask

    task automatic test_single_source();
        bit done;
        do_reset();
        s_axis_tvalid = 2'b01;
        push_src_block(0);
        push_src_block(0);
        run_blocks(1200, done);
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL t1_timeout pending=%0d, required 0", exp_q.size());
        end
        n_checks++;
        if (last_gap != 1) begin
            n_fail++; $display("FAIL t1_bubble got %0d cycles, required 1", last_gap);
        end
        n_checks++;
        if (block_cnt !== 16'd2) begin
            n_fail++; $display("FAIL t1_block_cnt got %0d, required 2", block_cnt);
        end
        n_checks++;
        if (src_hs[0] != 510 || src_hs[1] != 0) begin
            n_fail++; $display("FAIL t1_consumed got %0d/%0d, required 510/0", src_hs[0], src_hs[1]);
        end
    endtask

    task automatic test_round_robin();
        bit done;
        do_reset();
        s_axis_tvalid = 2'b11;
        push_src_block(0);
        push_src_block(1);
        push_src_block(0);
        push_src_block(1);
        run_blocks(2000, done);
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL t2_timeout pending=%0d, required 0", exp_q.size());
        end
        n_checks++;
        if (block_cnt !== 16'd4) begin
            n_fail++; $display("FAIL t2_block_cnt got %0d, required 4", block_cnt);
        end
        n_checks++;
        if (src_hs[0] != 510 || src_hs[1] != 510) begin
            n_fail++; $display("FAIL t2_consumed got %0d/%0d, required 510/510", src_hs[0], src_hs[1]);
        end
    endtask

    task automatic test_src_stall();
        bit done;
        int guard;
        do_reset();
        s_axis_tvalid = 2'b10;
        push_src_block(1);
        guard = 0;
        while (src_hs[1] < 100 && guard < 400) begin
            tick();
            guard++;
        end
        n_checks++;
        if (src_hs[1] != 100) begin
            n_fail++; $display("FAIL t3_reach100 got %0d bytes, required 100", src_hs[1]);
        end
        // src1 goes quiet; src0 requests but must not steal the grant.
        s_axis_tvalid = 2'b01;
        for (int c = 0; c < 20; c++) begin
            #1;
            n_checks++;
            if ({m_axis_tvalid, s_axis_tready, grant_busy} !== {1'b0, 2'b10, 1'b1}) begin
                n_fail++;
                $display("FAIL t3_hold_%0d got tvalid=%b tready=%b busy=%b, required tvalid=0 tready=10 busy=1",
                         c, m_axis_tvalid, s_axis_tready, grant_busy);
            end
            tick();
        end
        s_axis_tvalid = 2'b10;
        run_blocks(600, done);
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL t3_timeout pending=%0d, required 0", exp_q.size());
        end
        n_checks++;
        if (src_hs[1] != 255 || src_hs[0] != 0 || block_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL t3_totals got src1=%0d src0=%0d blocks=%0d, required 255 0 1",
                     src_hs[1], src_hs[0], block_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit done;
        int b0;
        do_reset();
        s_axis_tvalid = 2'b01;
        push_src_block(0);
        b0 = beat_cnt;
        done = 0;
        for (int c = 0; c < 1200; c++) begin
            m_axis_tready = ~m_axis_tready;
            tick();
            if (exp_q.size() == 0) begin
                s_axis_tvalid = '0;
                done = 1;
                break;
            end
        end
        m_axis_tready = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL t4_timeout pending=%0d, required 0", exp_q.size());
        end
        n_checks++;
        if (beat_cnt - b0 != 255) begin
            n_fail++; $display("FAIL t4_handshakes got %0d, required 255", beat_cnt - b0);
        end
        n_checks++;
        if (block_cnt !== 16'd1) begin
            n_fail++; $display("FAIL t4_block_cnt got %0d, required 1", block_cnt);
        end
    endtask

    task automatic test_reset_mid_block();
        bit done;
        int guard;
        do_reset();
        s_axis_tvalid = 2'b01;
        push_src_block(0);
        guard = 0;
        while (src_hs[0] < 50 && guard < 300) begin
            tick();
            guard++;
        end
        n_checks++;
        if (src_hs[0] != 50) begin
            n_fail++; $display("FAIL t5_reach50 got %0d bytes, required 50", src_hs[0]);
        end
        rst_n = 1'b0;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        n_checks++;
        if (block_cnt !== 16'd0 || grant_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_after_reset got blocks=%0d busy=%b, required 0 0", block_cnt, grant_busy);
        end
        // The abandoned block consumed bytes 0x00..0x31; the new block starts at 0x32.
        exp_next[0] = 8'd50;
        push_src_block(0);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 2'b01;
        repeat (10) tick();
        n_checks++;
        if (block_cnt !== 16'd0 || grant_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_mid_block got blocks=%0d busy=%b, required 0 1", block_cnt, grant_busy);
        end
        run_blocks(600, done);
        n_checks++;
        if (!done || block_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL t5_done got pending=%0d blocks=%0d, required 0 1", exp_q.size(), block_cnt);
        end
    endtask

`ifdef FILL_BLOCK_EN
    task automatic test_fill();
        bit done;
        int n;
        int b0;
        do_reset();
        n = 0;
        while (!m_axis_tvalid && n < 100) begin
            tick();
            #1;
            n++;
        end
        n_checks++;
        if (n != 16) begin
            n_fail++; $display("FAIL t6_fill_start got %0d idle cycles, required 16", n);
        end
        push_fill_block();
        b0 = beat_cnt;
        while (beat_cnt - b0 < 100 && n < 600) begin
            tick();
            n++;
        end
        s_axis_tvalid = 2'b01;
        push_src_block(0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({s_axis_tready, m_axis_tuser} !== {2'b00, 2'b11}) begin
                n_fail++;
                $display("FAIL t6_fill_hold got tready=%b tuser=%0d, required 00 3",
                         s_axis_tready, m_axis_tuser);
            end
            tick();
        end
        run_blocks(1000, done);
        n_checks++;
        if (!done || block_cnt !== 16'd2 || src_hs[0] != 255) begin
            n_fail++;
            $display("FAIL t6_done got pending=%0d blocks=%0d src0=%0d, required 0 2 255",
                     exp_q.size(), block_cnt, src_hs[0]);
        end
    endtask
`else
    task automatic test_no_fill();
        bit seen;
        do_reset();
        seen = 0;
        repeat (40) begin
            tick();
            if (m_axis_tvalid) seen = 1;
        end
        n_checks++;
        if (seen || grant_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_idle_hold got tvalid_seen=%b busy=%b, required 0 0", seen, grant_busy);
        end
    endtask
`endif

    initial begin
        src_byte[0] = 8'h00; src_byte[1] = 8'h80;
        exp_next[0] = 8'h00; exp_next[1] = 8'h80;
        src_hs[0] = 0; src_hs[1] = 0;
        s_axis_tdata = {src_byte[1], src_byte[0]};
        test_reset();
        test_single_source();
        test_round_robin();
        test_src_stall();
        test_backpressure();
        test_reset_mid_block();
`ifdef FILL_BLOCK_EN
        test_fill();
`else
        test_no_fill();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
